// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state codes and the
// bit-counter width helper.
package serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Counter only has to reach width-1, so clog2(width) bits suffice.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake plus operand and result buses between a lab
// controller (master) and the serial adder (slave).
interface serial_adder_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             cout;

    modport master (
        output start, A, B, cin,
        input  busy, done, S, cout
    );

    modport slave (
        input  start, A, B, cin,
        output busy, done, S, cout
    );

endinterface

// File: rtl/full_adder.sv
// One-bit full-adder slice; the only arithmetic in the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first through a single
// full-adder slice, with a start/busy/done handshake.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_sh;
    logic             carry;
    logic             cout_q;
    logic [CNT_W-1:0] cnt;
    logic             slice_s;
    logic             slice_c;
    logic             last_bit;

    full_adder u_slice (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .Cin  (carry),
        .S    (slice_s),
        .Cout (slice_c)
    );

    assign last_bit = (cnt == CNT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start) state_next = ST_RUN;
            ST_RUN:  if (last_bit)  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // busy/done come from flops loaded with the next-state decode, so they
    // are glitch-free and have no combinational path from start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next == ST_RUN) || (state_next == ST_DONE);
            done_q <= (state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            s_sh   <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        carry <= bus.cin;
                        s_sh  <= '0;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    // Sum bits enter at the MSB so the LSB lands at bit 0
                    // after exactly WIDTH shifts.
                    s_sh  <= {slice_s, s_sh[WIDTH-1:1]};
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= slice_c;
                    if (last_bit) begin
                        cout_q <= slice_c;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.S    = s_sh;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16 against a
// cycle-count / integer-sum model of the handshake.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  if8  ();
    serial_adder_if #(.WIDTH(16)) if16 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (if16)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: cycles remaining until IDLE, and the integer sum of the captured op.
    int          rem8, rem16;
    logic [8:0]  sum8;
    logic [16:0] sum16;
    logic [7:0]  ms8;
    logic        mc8;
    logic [15:0] ms16;
    logic        mc16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        rem8 = 0; rem16 = 0;
        sum8 = '0; sum16 = '0;
        ms8 = '0; mc8 = 1'b0;
        ms16 = '0; mc16 = 1'b0;
    endtask

    task automatic model_edge();
        if (rst) begin
            model_reset();
        end else begin
            if (rem8 == 0) begin
                if (if8.start) begin
                    rem8 = 8 + 1;
                    sum8 = 9'(if8.A) + 9'(if8.B) + 9'(if8.cin);
                end
            end else begin
                rem8--;
                if (rem8 == 1) {mc8, ms8} = sum8;
            end
            if (rem16 == 0) begin
                if (if16.start) begin
                    rem16 = 16 + 1;
                    sum16 = 17'(if16.A) + 17'(if16.B) + 17'(if16.cin);
                end
            end else begin
                rem16--;
                if (rem16 == 1) {mc16, ms16} = sum16;
            end
        end
    endtask

    task automatic compare();
        if (!rst) begin
            chk("busy8", 32'(if8.busy), 32'(rem8 != 0));
            chk("done8", 32'(if8.done), 32'(rem8 == 1));
            if (rem8 <= 1) begin
                chk("S8", 32'(if8.S), 32'(ms8));
                chk("cout8", 32'(if8.cout), 32'(mc8));
            end
            chk("busy16", 32'(if16.busy), 32'(rem16 != 0));
            chk("done16", 32'(if16.done), 32'(rem16 == 1));
            if (rem16 <= 1) begin
                chk("S16", 32'(if16.S), 32'(ms16));
                chk("cout16", 32'(if16.cout), 32'(mc16));
            end
        end
    endtask

    // Inputs change only after this returns (at the falling edge).
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [7:0] es, input logic ec);
        int lat;
        bit seen;
        if8.A = a; if8.B = b; if8.cin = ci; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(if8.busy), 32'(1));
        if8.A = ~a; if8.B = ~b; if8.cin = ~ci;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            step();
            lat++;
            if (if8.done) seen = 1'b1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(8));
        chk({tag, "_S"}, 32'(if8.S), 32'(es));
        chk({tag, "_cout"}, 32'(if8.cout), 32'(ec));
        chk({tag, "_model"}, 32'({mc8, ms8}), 32'({ec, es}));
        step();
        chk({tag, "_idle"}, 32'(if8.busy), 32'(0));
    endtask

    initial begin
        int dones;
        int d8, d16;
        rst = 1'b1;
        if8.start = 1'b0; if8.A = '0; if8.B = '0; if8.cin = 1'b0;
        if16.start = 1'b0; if16.A = '0; if16.B = '0; if16.cin = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_busy8", 32'(if8.busy), 32'(0));
        chk("rst_done8", 32'(if8.done), 32'(0));
        chk("rst_S8", 32'(if8.S), 32'(0));
        chk("rst_cout8", 32'(if8.cout), 32'(0));
        chk("rst_S16", 32'(if16.S), 32'(0));
        rst = 1'b0;
        step();

        op8("add_3c_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("add_cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        op8("ripple", 8'hAA, 8'h55, 1'b1, 8'h00, 1'b1);

        // Extra starts during RUN (edge 3) and DONE (edge 9) must be dropped.
        if8.A = 8'h10; if8.B = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
        step();
        dones = 0;
        for (int k = 1; k <= 12; k++) begin
            if8.start = (k == 3) || (k == 9);
            if8.A = if8.start ? 8'hFF : 8'h10;
            step();
            if (if8.done) dones++;
        end
        if8.start = 1'b0;
        chk("ignore_dones", 32'(dones), 32'(1));
        chk("ignore_S", 32'(if8.S), 32'(8'h30));
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_S", 32'(if8.S), 32'(8'h30));
            chk("hold_busy", 32'(if8.busy), 32'(0));
        end

        // Asynchronous abort in the middle of RUN.
        if8.A = 8'h3C; if8.B = 8'h05; if8.cin = 1'b0; if8.start = 1'b1;
        step();
        if8.start = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("pre_abort_busy", 32'(if8.busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(if8.busy), 32'(0));
        chk("abort_done", 32'(if8.done), 32'(0));
        chk("abort_S", 32'(if8.S), 32'(0));
        chk("abort_cout", 32'(if8.cout), 32'(0));
        model_reset();
        step();
        step();
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (if8.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'(0));
        op8("post_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Random operands on both widths; inputs scrambled after capture.
        for (int i = 0; i < 1000; i++) begin
            if8.A = 8'($urandom);  if8.B = 8'($urandom);  if8.cin = 1'($urandom);
            if16.A = 16'($urandom); if16.B = 16'($urandom); if16.cin = 1'($urandom);
            if8.start = 1'b1;
            if16.start = 1'b1;
            step();
            if8.start = 1'b0;
            if16.start = 1'b0;
            d8 = 0;
            d16 = 0;
            for (int j = 0; j < 18; j++) begin
                if8.A = 8'($urandom);  if8.B = 8'($urandom);  if8.cin = 1'($urandom);
                if16.A = 16'($urandom); if16.B = 16'($urandom); if16.cin = 1'($urandom);
                step();
                if (if8.done) d8++;
                if (if16.done) d16++;
            end
            chk("rand_dones8", 32'(d8), 32'(1));
            chk("rand_dones16", 32'(d16), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
